// File: rtl/proc_fetch_unit.sv
// TinyRV1 fetch stage: owns the PC, issues in-order imem requests, and holds
// returned instructions with their PCs in a reservation queue until decode takes them.
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  input  logic        redirect_val,
  input  logic [31:0] redirect_target,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       pc_q, pc_d;
  logic [QDEPTH-1:0] alloc_q, alloc_d;
  logic [QDEPTH-1:0] filled_q, filled_d;
  logic [31:0]       epc_q   [QDEPTH];
  logic [31:0]       epc_d   [QDEPTH];
  logic [31:0]       edata_q [QDEPTH];
  logic [31:0]       edata_d [QDEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     unfilled;
  logic              fire;
  logic              deq;

  // Requests are blocked while wrong-path responses are still owed to us.
  assign imemreq_val  = !rst && !redirect_val && (drop_cnt_q == '0) && (count_q < CW'(QDEPTH));
  assign imemreq_addr = pc_q;
  assign fire         = imemreq_val && imemreq_rdy;

  assign inst_val = !rst && !redirect_val && alloc_q[head_q] && filled_q[head_q];
  assign inst     = alloc_q[head_q] ? edata_q[head_q] : '0;
  assign inst_pc  = alloc_q[head_q] ? epc_q[head_q]   : '0;
  assign deq      = inst_val && inst_rdy;

  always_comb begin
    unfilled = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (alloc_q[i] && !filled_q[i]) unfilled = unfilled + CW'(1);
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    pc_d       = pc_q;
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    epc_d      = epc_q;
    edata_d    = edata_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (redirect_val) begin
      // In-flight requests for unfilled entries will still return and must be dropped;
      // a response landing this very cycle is already one of them.
      pc_d       = redirect_target;
      alloc_d    = '0;
      filled_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      drop_cnt_d = drop_cnt_q + unfilled - CW'(imemresp_val);
    end else begin
      if (fire) begin
        alloc_d[tail_q]  = 1'b1;
        filled_d[tail_q] = 1'b0;
        epc_d[tail_q]    = pc_q;
        tail_d           = tail_q + PW'(1);
        pc_d             = pc_q + 32'd4;
      end
      if (imemresp_val) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          edata_d[fill_q]  = imemresp_data;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PW'(1);
        end
      end
      if (deq) begin
        alloc_d[head_q]  = 1'b0;
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      count_d = count_q + CW'(fire) - CW'(deq);
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      alloc_q    <= '0;
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: entry payloads are not reset; alloc/filled qualify them, so stale contents are never used.
  always_ff @(posedge clk) begin
    epc_q   <= epc_d;
    edata_q <= edata_d;
  end

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Directed bench for proc_fetch_unit: a latency-configurable in-order memory model
// and per-scenario tasks with hand-derived cycle-by-cycle expectations.
module tb_proc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] got_pc    [$];

  proc_fetch_unit #(.RESET_PC(32'h0000_0200), .QDEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imemreq_val     (imemreq_val),
    .imemreq_rdy     (imemreq_rdy),
    .imemreq_addr    (imemreq_addr),
    .imemresp_val    (imemresp_val),
    .imemresp_data   (imemresp_data),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target),
    .inst_val        (inst_val),
    .inst_rdy        (inst_rdy),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Drive this cycle's memory response, then let combinational outputs settle.
  task automatic eval();
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      imemresp_val  = 1'b0;
      imemresp_data = '0;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imemresp_val  = 1'b1;
      imemresp_data = instr(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imemresp_val  = 1'b0;
      imemresp_data = '0;
    end
    #1;
  endtask

  // Record this cycle's handshakes, clock the DUT, return at the falling edge.
  task automatic advance();
    if (!rst && imemreq_val && imemreq_rdy) begin
      pend_addr.push_back(imemreq_addr);
      pend_due.push_back(cyc + mem_lat);
    end
    if (inst_val && inst_rdy) got_pc.push_back(inst_pc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut(input int lat);
    rst             = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = '0;
    imemreq_rdy     = 1'b1;
    inst_rdy        = 1'b1;
    mem_lat         = lat;
    for (int i = 0; i < 2; i++) begin
      eval();
      advance();
    end
    rst = 1'b0;
    cyc = 0;
    got_pc.delete();
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = '0;
    imemreq_rdy     = 1'b1;
    inst_rdy        = 1'b1;
    eval();
    advance();
    eval();
    n_assert++;
    if (imemreq_val !== 1'b0 || inst_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: imemreq_val=%b inst_val=%b, expected 0 0", imemreq_val, inst_val);
    end
    n_assert++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_inst: inst=%h inst_pc=%h, expected 0 0", inst, inst_pc);
    end
    advance();
    rst = 1'b0;
    cyc = 0;
    eval();
    n_assert++;
    if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h200 || inst_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: val=%b addr=%h inst_val=%b, expected 1 00000200 0",
               imemreq_val, imemreq_addr, inst_val);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ip;
    logic        iv;
    reset_dut(1);
    for (int k = 0; k < 10; k++) begin
      eval();
      ea = 32'h200 + 32'(4 * k);
      n_assert++;
      if (imemreq_val !== 1'b1 || imemreq_addr !== ea) begin
        n_fail++;
        $display("FAIL stream_req c%0d: val=%b addr=%h, expected 1 %h", k, imemreq_val, imemreq_addr, ea);
      end
      iv = (k >= 2);
      ip = 32'h200 + 32'(4 * (k - 2));
      n_assert++;
      if (inst_val !== iv || (iv && (inst_pc !== ip || inst !== instr(ip)))) begin
        n_fail++;
        $display("FAIL stream_inst c%0d: val=%b pc=%h inst=%h, expected %b %h %h",
                 k, inst_val, inst_pc, inst, iv, ip, instr(ip));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, ip;
    logic        ev, iv;
    reset_dut(1);
    for (int k = 0; k < 14; k++) begin
      inst_rdy = (k >= 8);
      eval();
      ev = (k < 4) || (k >= 9);
      ea = (k < 4) ? 32'h200 + 32'(4 * k) : 32'h210 + 32'(4 * (k - 9));
      n_assert++;
      if (imemreq_val !== ev || (ev && imemreq_addr !== ea)) begin
        n_fail++;
        $display("FAIL bp_req c%0d: val=%b addr=%h, expected %b %h", k, imemreq_val, imemreq_addr, ev, ea);
      end
      iv = (k >= 2);
      ip = (k < 8) ? 32'h200 : 32'h200 + 32'(4 * (k - 8));
      n_assert++;
      if (inst_val !== iv || (iv && (inst_pc !== ip || inst !== instr(ip)))) begin
        n_fail++;
        $display("FAIL bp_inst c%0d: val=%b pc=%h inst=%h, expected %b %h %h",
                 k, inst_val, inst_pc, inst, iv, ip, instr(ip));
      end
      advance();
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] ea;
    reset_dut(1);
    for (int k = 0; k < 8; k++) begin
      imemreq_rdy = (k >= 5);
      eval();
      ea = (k <= 5) ? 32'h200 : 32'h200 + 32'(4 * (k - 5));
      n_assert++;
      if (imemreq_val !== 1'b1 || imemreq_addr !== ea) begin
        n_fail++;
        $display("FAIL stall_req c%0d: val=%b addr=%h, expected 1 %h", k, imemreq_val, imemreq_addr, ea);
      end
      n_assert++;
      if (inst_val !== (k >= 7) || (k >= 7 && inst_pc !== 32'h200)) begin
        n_fail++;
        $display("FAIL stall_inst c%0d: val=%b pc=%h, expected %b 00000200", k, inst_val, inst_pc, k >= 7);
      end
      advance();
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] ea, ip;
    logic        ev, iv;
    reset_dut(3);
    for (int k = 0; k < 13; k++) begin
      imemreq_rdy     = (k != 2);
      redirect_val    = (k == 5);
      redirect_target = 32'h400;
      eval();
      case (k)
        0, 1, 2: begin ev = 1'b1; ea = 32'h200 + 32'(4 * k); end
        3:       begin ev = 1'b1; ea = 32'h208; end
        4:       begin ev = 1'b1; ea = 32'h20C; end
        5, 6, 7: begin ev = 1'b0; ea = '0; end
        12:      begin ev = 1'b0; ea = '0; end
        default: begin ev = 1'b1; ea = 32'h400 + 32'(4 * (k - 8)); end
      endcase
      n_assert++;
      if (imemreq_val !== ev || (ev && imemreq_addr !== ea)) begin
        n_fail++;
        $display("FAIL redir_req c%0d: val=%b addr=%h, expected %b %h", k, imemreq_val, imemreq_addr, ev, ea);
      end
      iv = (k == 4) || (k == 12);
      ip = (k == 4) ? 32'h200 : 32'h400;
      n_assert++;
      if (inst_val !== iv || (iv && (inst_pc !== ip || inst !== instr(ip)))) begin
        n_fail++;
        $display("FAIL redir_inst c%0d: val=%b pc=%h inst=%h, expected %b %h %h",
                 k, inst_val, inst_pc, inst, iv, ip, instr(ip));
      end
      advance();
    end
    redirect_val = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] ea, ip;
    logic        ev, iv;
    reset_dut(3);
    for (int k = 0; k < 12; k++) begin
      redirect_val    = (k == 5);
      redirect_target = 32'h600;
      eval();
      if (k == 5) begin
        n_assert++;
        if (imemresp_val !== 1'b1 || inst_val !== 1'b0) begin
          n_fail++;
          $display("FAIL same_cycle_setup: resp_val=%b inst_val=%b, expected 1 0", imemresp_val, inst_val);
        end
      end
      ev = (k < 4) || (k >= 7 && k <= 10);
      ea = (k < 4) ? 32'h200 + 32'(4 * k) : 32'h600 + 32'(4 * (k - 7));
      n_assert++;
      if (imemreq_val !== ev || (ev && imemreq_addr !== ea)) begin
        n_fail++;
        $display("FAIL same_req c%0d: val=%b addr=%h, expected %b %h", k, imemreq_val, imemreq_addr, ev, ea);
      end
      iv = (k == 4) || (k == 11);
      ip = (k == 4) ? 32'h200 : 32'h600;
      n_assert++;
      if (inst_val !== iv || (iv && (inst_pc !== ip || inst !== instr(ip)))) begin
        n_fail++;
        $display("FAIL same_inst c%0d: val=%b pc=%h inst=%h, expected %b %h %h",
                 k, inst_val, inst_pc, inst, iv, ip, instr(ip));
      end
      advance();
    end
    redirect_val = 1'b0;
    n_assert++;
    if (got_pc.size() != 2 || got_pc[0] !== 32'h200 || got_pc[1] !== 32'h600) begin
      n_fail++;
      $display("FAIL same_delivered: count=%0d first=%h second=%h, expected 2 00000200 00000600",
               got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx,
               (got_pc.size() > 1) ? got_pc[1] : 32'hx);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] ip;
    reset_dut(1);
    inst_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval();
      advance();
    end
    eval();
    n_assert++;
    if (inst_val !== 1'b1 || inst_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL midrst_queued: inst_val=%b pc=%h, expected 1 00000200", inst_val, inst_pc);
    end
    rst = 1'b1;
    eval();
    n_assert++;
    if (imemreq_val !== 1'b0 || inst_val !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: req_val=%b inst_val=%b, expected 0 0", imemreq_val, inst_val);
    end
    advance();
    eval();
    n_assert++;
    if (imemreq_val !== 1'b0 || inst_val !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_after: req_val=%b inst_val=%b inst=%h pc=%h, expected 0 0 0 0",
               imemreq_val, inst_val, inst, inst_pc);
    end
    advance();
    rst      = 1'b0;
    inst_rdy = 1'b1;
    cyc      = 0;
    for (int k = 0; k < 5; k++) begin
      eval();
      n_assert++;
      if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h200 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL midrst_req c%0d: val=%b addr=%h, expected 1 %h",
                 k, imemreq_val, imemreq_addr, 32'h200 + 32'(4 * k));
      end
      ip = 32'h200 + 32'(4 * (k - 2));
      n_assert++;
      if (inst_val !== (k >= 2) || (k >= 2 && inst_pc !== ip)) begin
        n_fail++;
        $display("FAIL midrst_inst c%0d: val=%b pc=%h, expected %b %h", k, inst_val, inst_pc, k >= 2, ip);
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    imemreq_rdy     = 1'b0;
    imemresp_val    = 1'b0;
    imemresp_data   = '0;
    redirect_val    = 1'b0;
    redirect_target = '0;
    inst_rdy        = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_fetch_unit.md
Name: proc_fetch_unit

Overview:
- Fetch stage of the pipelined TinyRV1 processor. It sits directly upstream of the decode stage's instruction register.
- Owns the PC and issues in-order requests to instruction memory using a val/rdy request channel and an always-accepted response channel.
- Holds returned instructions, each paired with its PC, in a reservation queue until decode consumes them via a val/rdy handshake.
- Handles control-flow redirects by flushing the queue and discarding wrong-path responses still in flight.

Parameters:
RESET_PC, 32'h00000200, PC loaded on reset.
QDEPTH, 4, reservation queue entries (power of 2, >=2); also the maximum number of outstanding memory requests.

Ports:
clk  input  1  clock
rst  input  1  reset
imemreq_val  output  1  fetch request valid
imemreq_rdy  input  1  memory accepts request
imemreq_addr  output  32  fetch address (= pc)
imemresp_val  input  1  response valid; always accepted; responses return in order
imemresp_data  input  32  fetched instruction
redirect_val  input  1  redirect PC (branch/jump resolved downstream)
redirect_target  input  32  new PC
inst_val  output  1  instruction available to decode
inst_rdy  input  1  decode accepts instruction
inst  output  32  instruction at queue head
inst_pc  output  32  PC of inst

Behaviour:
- Reset: one clock, synchronous, active-high on rst.
  - pc <= RESET_PC; queue emptied (all entries free, all pointers 0); drop_cnt <= 0.
  - During and after reset: imemreq_val=0, inst_val=0, inst=0, inst_pc=0 when the queue is empty.
  - Responses to requests issued before reset are the environment's responsibility; the memory is reset alongside this block.
- Entry state: alloc, filled, pc[31:0], data[31:0]. Pointers: head, tail, fill (log2(QDEPTH) bits, wrap modulo QDEPTH). count = number of allocated entries (0..QDEPTH).
- Request issue:
  - imemreq_val = !redirect_val && drop_cnt==0 && count<QDEPTH.
  - imemreq_addr = pc at all times.
  - Fire = imemreq_val && imemreq_rdy. On fire: allocate entry[tail] with pc, filled=0; tail++; pc <= pc+4 (mod 2^32).
  - While val is high and rdy is low, addr holds.
- Response:
  - If drop_cnt>0: drop_cnt--, data is discarded.
  - Else: entry[fill].data <= imemresp_data, filled <= 1, fill++.
  - A response arriving with drop_cnt==0 and no unfilled entry is a protocol error; the bench asserts on it.
- Output to decode:
  - inst_val = entry[head].alloc && entry[head].filled && !redirect_val.
  - inst and inst_pc are driven from entry[head].
  - On inst_val && inst_rdy: free head, head++.
  - A slot freed by dequeue is not reusable for issue in the same cycle (count is taken from registered state).
  - Response-to-inst_val latency: 1 cycle.
  - Minimum fetch latency with memory latency 1: request in cycle t, inst_val in cycle t+2.
  - QDEPTH>=3 gives one instruction per cycle sustained throughput.
- Redirect (highest priority):
  - In the redirect_val cycle: no request issues, no dequeue.
  - On the edge: pc <= redirect_target; all entries freed; head=tail=fill=0.
  - drop_cnt <= drop_cnt + U - imemresp_val, where U = number of allocated-but-unfilled entries before the edge. A response arriving in the same cycle is discarded.
  - drop_cnt is at most QDEPTH and is 1+log2(QDEPTH) bits wide. Requests are blocked until drop_cnt==0.
  - Back-to-back redirects: the last target wins; drop counts accumulate per the formula above.
- Simultaneous allocate, fill and dequeue in one cycle are all legal and independent (distinct pointers).
- Queue full (count==QDEPTH): no issue. Queue empty: inst_val=0.

Test Plan:
1. Reset, then rst=0; memory latency 1; imemreq_rdy=1; inst_rdy=1.
   -> Requests to 0x200, 0x204, 0x208… on consecutive cycles.
   -> inst_val first high 2 cycles after the first request with inst_pc=0x200.
   -> Thereafter one instruction per cycle with inst_pc incrementing by 4.
2. inst_rdy=0 from the start.
   -> Exactly 4 requests (0x200–0x20C), then imemreq_val=0.
   -> inst/inst_pc hold 0x200 entry stably.
   -> Raise inst_rdy: 4 instructions drain in order, then issue resumes at 0x210.
3. Memory latency 3; redirect_val for 1 cycle to 0x400 while 2 requests (0x208, 0x20C) are outstanding.
   -> The next 2 responses are discarded; imemreq_val stays low until both arrive.
   -> Next request addr=0x400; next delivered inst_pc=0x400.
4. imemreq_rdy=0 for 5 cycles after reset.
   -> imemreq_val=1 and addr=0x200 held all 5 cycles; pc unchanged.
   -> The first fire happens on the cycle rdy rises.
5. Redirect in the same cycle as imemresp_val, with inst_val pending and inst_rdy=1.
   -> inst_val=0 that cycle, no dequeue.
   -> Response discarded; drop_cnt = U−1.
   -> After the drops drain, only target-path instructions appear.
6. Assert rst with 3 entries queued.
   -> Next cycle: inst_val=0, imemreq_val=0.
   -> After rst falls: fetch restarts at 0x200 and no stale instruction is delivered.
